memory_instruction_queue: RTL

//  Buffers superscalar memory-instruction bundles written by the control unit.

---
 rtl/memory_instruction_queue.sv | 124 ++++++++++++
 1 files changed

// File: rtl/memory_instruction_queue.sv
// Bundle queue between the control unit and the APU memory ports.
// Each stored bundle is drained one lane per cycle, lane 0 first, up to its lane count.
module memory_instruction_queue #(
    parameter int unsigned MEMORY_ADDRESS_BITS   = 15,
    parameter int unsigned SUPERSCALAR_LOG_WIDTH = 2,
    parameter int unsigned QUEUE_LOG_DEPTH       = 3,
    localparam int unsigned SW     = 1 << SUPERSCALAR_LOG_WIDTH,
    localparam int unsigned LANE_W = 15 + 3 * MEMORY_ADDRESS_BITS,
    localparam int unsigned DEPTH  = 1 << QUEUE_LOG_DEPTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [LANE_W*SW-1:0]             in_bundle,
    input  logic [SUPERSCALAR_LOG_WIDTH-1:0] in_count,
    input  logic                             in_we,
    output logic                             full,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANE_W-1:0]                out_lane_data,
    output logic [SUPERSCALAR_LOG_WIDTH-1:0] out_lane_idx,
    output logic                             out_last,
    output logic [QUEUE_LOG_DEPTH:0]         occupancy,
    output logic                             overflow
);

    localparam logic [QUEUE_LOG_DEPTH-1:0]       PtrOne    = 1;
    localparam logic [QUEUE_LOG_DEPTH:0]         OccOne    = 1;
    localparam logic [QUEUE_LOG_DEPTH:0]         OccFull   = DEPTH[QUEUE_LOG_DEPTH:0];
    localparam logic [SUPERSCALAR_LOG_WIDTH-1:0] LaneOne   = 1;

    // Bundle storage; data path only, so no reset.
    logic [LANE_W*SW-1:0]             bundle_mem [DEPTH];
    logic [SUPERSCALAR_LOG_WIDTH-1:0] count_mem  [DEPTH];

    logic [QUEUE_LOG_DEPTH-1:0]       rd_ptr_q, rd_ptr_d;
    logic [QUEUE_LOG_DEPTH-1:0]       wr_ptr_q, wr_ptr_d;
    logic [QUEUE_LOG_DEPTH:0]         occ_q, occ_d;
    logic [SUPERSCALAR_LOG_WIDTH-1:0] lane_idx_q, lane_idx_d;
    logic                             overflow_q, overflow_d;

    logic [LANE_W-1:0]                head_lanes [SW];
    logic                             push, xfer, pop;

    // Head bundle split into lanes, lane 0 taken from the MSBs.
    always_comb begin
        for (int i = 0; i < SW; i++) begin
            head_lanes[i] = bundle_mem[rd_ptr_q][(SW-1-i)*LANE_W +: LANE_W];
        end
    end

    // Output view and handshake decode; full is sampled before any same-cycle pop.
    always_comb begin
        full          = (occ_q == OccFull);
        out_valid     = (occ_q != '0);
        out_lane_data = head_lanes[lane_idx_q];
        out_lane_idx  = lane_idx_q;
        out_last      = out_valid && (lane_idx_q == count_mem[rd_ptr_q]);
        occupancy     = occ_q;
        overflow      = overflow_q;
        push          = in_we && !full && !flush;
        xfer          = out_valid && out_ready && !flush;
        pop           = xfer && out_last;
    end

    // Next-state for pointers, lane index, occupancy and sticky overflow.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        lane_idx_d = lane_idx_q;
        overflow_d = overflow_q;
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            occ_d      = '0;
            lane_idx_d = '0;
        end else begin
            if (in_we && full) begin
                overflow_d = 1'b1;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PtrOne;
                lane_idx_d = '0;
            end else if (xfer) begin
                lane_idx_d = lane_idx_q + LaneOne;
            end
            if (push && !pop) begin
                occ_d = occ_q + OccOne;
            end else if (pop && !push) begin
                occ_d = occ_q - OccOne;
            end
        end
    end

    // Control state register; reset dominates flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            lane_idx_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            lane_idx_q <= lane_idx_d;
            overflow_q <= overflow_d;
        end
    end

    // Slot write on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            bundle_mem[wr_ptr_q] <= in_bundle;
            count_mem[wr_ptr_q]  <= in_count;
        end
    end

endmodule
